fft_job_arbiter: RTL and testbench
==================================

// Module: fft_job_arbiter
// PURPOSE
// Owns the shared 2048x256 frame BRAM between the PCIe host path and the FFT engine, and sequences one FFT job per host doorbell.
// Drives pc_select, the port-A address/data/enable mux, the engine init pulse, and the MSI user interrupt handshake.
// Sits between the PCIe BRAM bridge, the frame BRAM and the FFT engine in the FFT top level. Port-B muxing stays external, keyed on pc_select.
// PARAMETERS
// AW        11     BRAM word address width
// DW        256    BRAM data width
// WDOG_CYC  65536  engine run timeout in clk_250M cycles (used only with ARB_WATCHDOG_EN)
// PORTS
// clk_250M       in   1    sole clock
// rst            in   1    synchronous reset, active-high
// host_start     in   1    doorbell pulse: start one job
// host_ifft      in   1    direction for the job (1 = inverse), sampled with host_start
// host_mode      in   2    FFT mode for the job, sampled with host_start
// host_en        in   1    host port-A enable
// host_we        in   1    host port-A write enable
// host_addr      in   AW   host port-A word address
// host_din       in   DW   host port-A write data
// eng_addr       in   AW   engine port-A read address
// eng_busy       in   1    engine busy (fft_ing)
// bram_ena       out  1    port-A enable
// bram_wea       out  1    port-A write enable
// bram_addra     out  AW   port-A address
// bram_dina      out  DW   port-A write data
// pc_select      out  1    1 = host owns the BRAM, 0 = engine owns it
// eng_init       out  1    one-cycle engine start pulse
// eng_ifft       out  1    latched direction
// eng_mode       out  2    latched mode
// usr_irq_req    out  1    MSI request, held high until acknowledged
// usr_irq_ack    in   1    MSI acknowledge
// host_err       out  1    sticky flag: host access or doorbell while the engine owns the BRAM
// wdog_timeout   out  1    sticky flag: last job was aborted by the watchdog
// job_cnt        out  16   completed jobs; wraps from 0xFFFF to 0
// BEHAVIOUR
// Reset values: state IDLE, pc_select 1, eng_init 0, usr_irq_req 0, eng_ifft 0, eng_mode 0, host_err 0, wdog_timeout 0, job_cnt 0.
// Port-A mux is combinational on registered pc_select:
//   pc_select=1: bram_ena = host_en; bram_wea = host_en & host_we; bram_addra = host_addr; bram_dina = host_din.
//   pc_select=0: bram_ena = 1; bram_wea = 0; bram_addra = eng_addr; bram_dina = 0.
// FSM:
//   IDLE  - host owns the BRAM. On host_start: latch host_ifft/host_mode, go to ARM.
//           A host write in the same cycle as host_start still completes.
//   ARM   - pc_select=0 (registered; first engine-owned cycle is N+1 after a doorbell at cycle N). Next state: START.
//   START - eng_init=1 for exactly this cycle (N+2). Clear seen_busy. Go to RUN.
//   RUN   - Set seen_busy when eng_busy=1. When seen_busy=1 and eng_busy=0, go to IRQ and increment job_cnt.
//   IRQ   - usr_irq_req=1; pc_select returns to 1 on entry, so the host can read results at once.
//           On usr_irq_ack=1: drop usr_irq_req the next cycle and go to IDLE.
//           An ack arriving in the entry cycle is honoured.
// Acks received outside IRQ are ignored.
// host_start outside IDLE is ignored and sets host_err. host_en=1 while pc_select=0 is dropped (no write reaches the BRAM) and sets host_err.
// Only rst clears host_err and wdog_timeout.
// Reset mid-job forces IDLE at once, with no interrupt and job_cnt unchanged. The engine sees no further eng_init.
// Back-to-back doorbells: a new host_start is accepted only in IDLE, at the earliest the cycle after the IRQ ack.
// CONFIGURATION
// ARB_WATCHDOG_EN defined:
//   - A 17-bit counter clears in START and counts every RUN cycle.
//   - Reaching WDOG_CYC goes to IRQ, sets wdog_timeout and does not increment job_cnt.
// ARB_WATCHDOG_EN undefined: RUN waits indefinitely; wdog_timeout is tied to 0; no counter logic.
// TESTING
// 1. Reset: assert rst for 2 cycles. Expect pc_select=1, usr_irq_req=0, job_cnt=0, and bram_addra following host_addr.
// 2. Host write addr 0x005, din 0xA5..A5, then read it back. Expect bram_wea=1 only on the write cycle; bram_ena equals host_en.
// 3. Doorbell at cycle N with mode=2, ifft=1.
//    Expect pc_select=0 at N+1, eng_init=1 only at N+2, eng_mode=2, eng_ifft=1, and bram_addra equal to eng_addr.
//    Then drive eng_busy high for 100 cycles.
//    Expect usr_irq_req=1 the cycle after busy falls; ack -> IDLE; job_cnt=1.
// 4. During RUN: pulse host_start, and drive host_we=1 to addr 0x010.
//    Expect no second eng_init, bram_wea=0, host_err=1, and the addr 0x010 contents unchanged.
// 5. Assert rst during RUN. Expect pc_select=1 and usr_irq_req=0 the next cycle; job_cnt unchanged; eng_busy then ignored.
// 6. With ARB_WATCHDOG_EN, WDOG_CYC=64, eng_busy held high: expect usr_irq_req after 64 RUN cycles, wdog_timeout=1, job_cnt unchanged.
//    Without the macro: no IRQ after 10000 cycles.

Source files
------------

// File: rtl/fft_job_arbiter_if.sv
// Port-A, engine and interrupt signals between the FFT frame-BRAM arbiter and its neighbours.
// master: arbiter side. slave: host bridge / engine / BRAM side.
interface fft_job_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 256
);
  logic          host_start;
  logic          host_ifft;
  logic [1:0]    host_mode;
  logic          host_en;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din;
  logic [AW-1:0] eng_addr;
  logic          eng_busy;
  logic          bram_ena;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic          pc_select;
  logic          eng_init;
  logic          eng_ifft;
  logic [1:0]    eng_mode;
  logic          usr_irq_req;
  logic          usr_irq_ack;
  logic          host_err;
  logic          wdog_timeout;
  logic [15:0]   job_cnt;

  modport master (
    input  host_start, host_ifft, host_mode, host_en, host_we, host_addr, host_din,
           eng_addr, eng_busy, usr_irq_ack,
    output bram_ena, bram_wea, bram_addra, bram_dina, pc_select, eng_init,
           eng_ifft, eng_mode, usr_irq_req, host_err, wdog_timeout, job_cnt
  );

  modport slave (
    output host_start, host_ifft, host_mode, host_en, host_we, host_addr, host_din,
           eng_addr, eng_busy, usr_irq_ack,
    input  bram_ena, bram_wea, bram_addra, bram_dina, pc_select, eng_init,
           eng_ifft, eng_mode, usr_irq_req, host_err, wdog_timeout, job_cnt
  );
endinterface

// File: rtl/fft_job_arbiter.sv
// Frame-BRAM owner arbiter: runs one FFT job per host doorbell and raises the MSI on completion.
// Optional run watchdog is enabled by defining ARB_WATCHDOG_EN.
//
// state | meaning
// IDLE  | host owns the BRAM, waiting for a doorbell
// ARM   | engine owns the BRAM, one settling cycle before the start pulse
// START | eng_init pulse
// RUN   | waiting for the engine busy pulse to rise and fall
// IRQ   | host owns the BRAM again, interrupt held until acknowledged
module fft_job_arbiter #(
  parameter int AW = 11,
  parameter int DW = 256
`ifdef ARB_WATCHDOG_EN
  , parameter int unsigned WDOG_CYC = 65536
`endif
) (
  input logic               clk_250M,
  input logic               rst,
  fft_job_arbiter_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_RUN, S_IRQ} state_t;

  state_t      state_q, state_d;
  logic        pc_select_q, pc_select_d;
  logic        eng_init_q, eng_init_d;
  logic        usr_irq_req_q, usr_irq_req_d;
  logic        eng_ifft_q, eng_ifft_d;
  logic [1:0]  eng_mode_q, eng_mode_d;
  logic        host_err_q, host_err_d;
  logic        seen_busy_q, seen_busy_d;
  logic [15:0] job_cnt_q, job_cnt_d;
  logic        wdog_timeout_q, wdog_timeout_d;
`ifdef ARB_WATCHDOG_EN
  localparam logic [16:0] WDOG_LIM = 17'(WDOG_CYC);
  logic [16:0] wdog_cnt_q, wdog_cnt_d;
`endif

  always_ff @(posedge clk_250M) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_select_q    <= 1'b1;
      eng_init_q     <= 1'b0;
      usr_irq_req_q  <= 1'b0;
      eng_ifft_q     <= 1'b0;
      eng_mode_q     <= 2'd0;
      host_err_q     <= 1'b0;
      seen_busy_q    <= 1'b0;
      job_cnt_q      <= 16'd0;
      wdog_timeout_q <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      wdog_cnt_q     <= 17'd0;
`endif
    end else begin
      state_q        <= state_d;
      pc_select_q    <= pc_select_d;
      eng_init_q     <= eng_init_d;
      usr_irq_req_q  <= usr_irq_req_d;
      eng_ifft_q     <= eng_ifft_d;
      eng_mode_q     <= eng_mode_d;
      host_err_q     <= host_err_d;
      seen_busy_q    <= seen_busy_d;
      job_cnt_q      <= job_cnt_d;
      wdog_timeout_q <= wdog_timeout_d;
`ifdef ARB_WATCHDOG_EN
      wdog_cnt_q     <= wdog_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    eng_ifft_d     = eng_ifft_q;
    eng_mode_d     = eng_mode_q;
    host_err_d     = host_err_q;
    seen_busy_d    = seen_busy_q;
    job_cnt_d      = job_cnt_q;
    wdog_timeout_d = wdog_timeout_q;
`ifdef ARB_WATCHDOG_EN
    wdog_cnt_d     = wdog_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.host_start) begin
          eng_ifft_d = bus.host_ifft;
          eng_mode_d = bus.host_mode;
          state_d    = S_ARM;
        end
      end
      S_ARM:   state_d = S_START;
      S_START: begin
        seen_busy_d = 1'b0;
`ifdef ARB_WATCHDOG_EN
        wdog_cnt_d  = 17'd0;
`endif
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (bus.eng_busy) seen_busy_d = 1'b1;
        if (seen_busy_q && !bus.eng_busy) begin
          job_cnt_d = job_cnt_q + 16'd1;
          state_d   = S_IRQ;
        end
`ifdef ARB_WATCHDOG_EN
        else begin
          wdog_cnt_d = wdog_cnt_q + 17'd1;
          if (wdog_cnt_d == WDOG_LIM) begin
            wdog_timeout_d = 1'b1;
            state_d        = S_IRQ;
          end
        end
`endif
      end
      S_IRQ: begin
        if (bus.usr_irq_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Doorbells outside IDLE and host accesses while the engine owns port A are dropped.
    if (bus.host_start && (state_q != S_IDLE)) host_err_d = 1'b1;
    if (bus.host_en && !pc_select_q)           host_err_d = 1'b1;

    pc_select_d   = (state_d == S_IDLE) || (state_d == S_IRQ);
    eng_init_d    = (state_d == S_START);
    usr_irq_req_d = (state_d == S_IRQ);
  end

  always_comb begin
    if (pc_select_q) begin
      bus.bram_ena   = bus.host_en;
      bus.bram_wea   = bus.host_en & bus.host_we;
      bus.bram_addra = bus.host_addr;
      bus.bram_dina  = bus.host_din;
    end else begin
      bus.bram_ena   = 1'b1;
      bus.bram_wea   = 1'b0;
      bus.bram_addra = bus.eng_addr;
      bus.bram_dina  = '0;
    end
  end

  assign bus.pc_select    = pc_select_q;
  assign bus.eng_init     = eng_init_q;
  assign bus.usr_irq_req  = usr_irq_req_q;
  assign bus.eng_ifft     = eng_ifft_q;
  assign bus.eng_mode     = eng_mode_q;
  assign bus.host_err     = host_err_q;
  assign bus.job_cnt      = job_cnt_q;
`ifdef ARB_WATCHDOG_EN
  assign bus.wdog_timeout = wdog_timeout_q;
`else
  assign bus.wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_job_arbiter.sv
// Self-checking bench for fft_job_arbiter: job-level reference model plus directed and random stimulus.
// Build with ARB_WATCHDOG_EN defined to exercise the watchdog (WDOG_CYC = 64).
module tb_fft_job_arbiter;
  localparam int AW = 11;
  localparam int DW = 256;
`ifdef ARB_WATCHDOG_EN
  localparam int WDOG = 64;
`endif

  logic clk;
  logic rst;
  fft_job_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  fft_job_arbiter #(
    .AW(AW), .DW(DW)
`ifdef ARB_WATCHDOG_EN
    , .WDOG_CYC(WDOG)
`endif
  ) dut (
    .clk_250M(clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: a job is active from the accepted doorbell until the ack;
  // m_age counts cycles since the doorbell (1 = first engine-owned cycle).
  bit          m_act, m_irq, m_seen, m_ifft, m_err, m_wdf;
  int          m_age;
  logic [1:0]  m_mode;
  logic [15:0] m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_irq = 0; m_seen = 0; m_ifft = 0; m_err = 0; m_wdf = 0;
      m_age = 0; m_mode = 2'd0; m_cnt = 16'd0;
    end else begin
      if (bus.host_start && m_act)              m_err = 1;
      if (bus.host_en && m_act && !m_irq)       m_err = 1;
      if (!m_act) begin
        if (bus.host_start) begin
          m_act = 1; m_age = 1; m_seen = 0;
          m_ifft = bus.host_ifft; m_mode = bus.host_mode;
        end
      end else if (m_irq) begin
        if (bus.usr_irq_ack) begin m_act = 0; m_irq = 0; end
      end else begin
        if (m_age >= 3) begin
          if (m_seen && !bus.eng_busy) begin
            m_irq = 1; m_cnt = m_cnt + 16'd1;
          end
`ifdef ARB_WATCHDOG_EN
          else if (m_age - 2 == WDOG) begin
            m_irq = 1; m_wdf = 1;
          end
`endif
          if (bus.eng_busy) m_seen = 1;
        end
        m_age++;
      end
    end
  end

  // BRAM stand-in written from port A; compare process runs on the falling edge.
  logic [DW-1:0] mem [0:2047];
  bit e_pc;

  always @(negedge clk) begin
    if (chk_en) begin
      e_pc = !(m_act && !m_irq);
      chk("pc_select",   256'(bus.pc_select),   256'(e_pc));
      chk("eng_init",    256'(bus.eng_init),    256'(m_act && !m_irq && m_age == 2));
      chk("usr_irq_req", 256'(bus.usr_irq_req), 256'(m_irq));
      chk("eng_ifft",    256'(bus.eng_ifft),    256'(m_ifft));
      chk("eng_mode",    256'(bus.eng_mode),    256'(m_mode));
      chk("host_err",    256'(bus.host_err),    256'(m_err));
      chk("wdog_timeout",256'(bus.wdog_timeout),256'(m_wdf));
      chk("job_cnt",     256'(bus.job_cnt),     256'(m_cnt));
      chk("bram_ena",    256'(bus.bram_ena),    256'(e_pc ? bus.host_en : 1'b1));
      chk("bram_wea",    256'(bus.bram_wea),    256'(e_pc ? (bus.host_en & bus.host_we) : 1'b0));
      chk("bram_addra",  256'(bus.bram_addra),  256'(e_pc ? bus.host_addr : bus.eng_addr));
      chk("bram_dina",   256'(bus.bram_dina),   256'(e_pc ? bus.host_din : '0));
    end
    if (bus.bram_ena === 1'b1 && bus.bram_wea === 1'b1) mem[bus.bram_addra] = bus.bram_dina;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doorbell(input logic [1:0] mode, input logic ifft);
    bus.host_start = 1'b1; bus.host_mode = mode; bus.host_ifft = ifft;
    tick();
    bus.host_start = 1'b0;
  endtask

  logic [DW-1:0] pat_a5, pat_3c;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    pat_a5 = {32{8'hA5}};
    pat_3c = {32{8'h3C}};
    rst = 1'b1;
    bus.host_start = 0; bus.host_ifft = 0; bus.host_mode = 2'd0;
    bus.host_en = 0; bus.host_we = 0; bus.host_addr = 11'h123; bus.host_din = '0;
    bus.eng_addr = 11'h456; bus.eng_busy = 0; bus.usr_irq_ack = 0;

    // reset
    tick(); tick();
    chk_en = 1;
    chk("rst_pc_select", 256'(bus.pc_select), 256'(1));
    chk("rst_irq",       256'(bus.usr_irq_req), 256'(0));
    chk("rst_job_cnt",   256'(bus.job_cnt), 256'(0));
    chk("rst_addra",     256'(bus.bram_addra), 256'(11'h123));
    rst = 1'b0;

    // host write then read-back
    bus.host_en = 1; bus.host_we = 1; bus.host_addr = 11'h005; bus.host_din = pat_a5;
    tick();
    bus.host_we = 0; bus.host_din = '0;
    tick();
    bus.host_en = 1; bus.host_we = 1; bus.host_addr = 11'h010; bus.host_din = pat_3c;
    tick();
    bus.host_en = 0; bus.host_we = 0;
    tick();
    chk("mem_005", mem[5], pat_a5);

    // reset in the middle of a job
    doorbell(2'd1, 1'b0);
    tick(); tick();
    bus.eng_busy = 1;
    repeat (5) tick();
    rst = 1;
    tick();
    chk("midrst_pc",   256'(bus.pc_select), 256'(1));
    chk("midrst_irq",  256'(bus.usr_irq_req), 256'(0));
    chk("midrst_cnt",  256'(bus.job_cnt), 256'(0));
    rst = 0;
    repeat (3) tick();
    bus.eng_busy = 0;
    repeat (10) tick();
    chk("midrst_noirq", 256'(bus.usr_irq_req), 256'(0));

    // doorbell mode 2, inverse; illegal host activity during RUN
    bus.eng_addr = 11'h7AB;
    doorbell(2'd2, 1'b1);
    chk("n1_pc_select", 256'(bus.pc_select), 256'(0));
    tick();
    chk("n2_eng_init",  256'(bus.eng_init), 256'(1));
    chk("n2_eng_mode",  256'(bus.eng_mode), 256'(2));
    chk("n2_eng_ifft",  256'(bus.eng_ifft), 256'(1));
    chk("n2_addra",     256'(bus.bram_addra), 256'(11'h7AB));
    tick();
    chk("n3_eng_init",  256'(bus.eng_init), 256'(0));
    bus.host_start = 1; bus.host_en = 1; bus.host_we = 1;
    bus.host_addr = 11'h010; bus.host_din = ~pat_3c;
    tick();
    bus.host_start = 0; bus.host_en = 0; bus.host_we = 0;
    bus.eng_busy = 1;
    repeat (100) tick();
    bus.eng_busy = 0;
    tick();
    chk("done_irq",     256'(bus.usr_irq_req), 256'(1));
    chk("done_pc",      256'(bus.pc_select), 256'(1));
    chk("done_job_cnt", 256'(bus.job_cnt), 256'(1));
    chk("done_herr",    256'(bus.host_err), 256'(1));
    chk("mem_010",      mem[16], pat_3c);
    bus.usr_irq_ack = 1;
    tick();
    bus.usr_irq_ack = 0;
    chk("ack_irq", 256'(bus.usr_irq_req), 256'(0));

    // engine stuck busy
    doorbell(2'd0, 1'b0);
    tick();
    bus.eng_busy = 1;
    repeat (10000) tick();
`ifdef ARB_WATCHDOG_EN
    chk("wdog_irq",  256'(bus.usr_irq_req), 256'(1));
    chk("wdog_flag", 256'(bus.wdog_timeout), 256'(1));
    chk("wdog_cnt",  256'(bus.job_cnt), 256'(1));
`else
    chk("stuck_noirq", 256'(bus.usr_irq_req), 256'(0));
    chk("stuck_pc",    256'(bus.pc_select), 256'(0));
`endif
    bus.eng_busy = 0;
    tick(); tick();
    bus.usr_irq_ack = 1;
    tick();
    bus.usr_irq_ack = 0;
    tick();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst             = ($urandom_range(0, 499) == 0);
      bus.host_start  = ($urandom_range(0, 11) == 0);
      bus.host_ifft   = 1'($urandom_range(0, 1));
      bus.host_mode   = 2'($urandom_range(0, 3));
      bus.host_en     = 1'($urandom_range(0, 1));
      bus.host_we     = 1'($urandom_range(0, 1));
      bus.host_addr   = 11'($urandom_range(0, 2047));
      bus.host_din    = {8{$urandom()}};
      bus.eng_addr    = 11'($urandom_range(0, 2047));
      bus.eng_busy    = ($urandom_range(0, 2) != 0);
      bus.usr_irq_ack = ($urandom_range(0, 4) == 0);
      tick();
    end
    rst = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
